// File: rtl/csk_wide_add_seq_pkg.sv
// Shared types and constants for the multi-word carry-skip add sequencer.
// Holds the word width, FSM encoding, requester id type and the arbiter grant rule.
package csk_wide_add_seq_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CSK_BLK = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef logic req_id_t;

    // Bit 0 grants requester 0, bit 1 grants requester 1; rr breaks ties.
    function automatic logic [1:0] arb_grant(input logic v0, input logic v1, input req_id_t rr);
        if (v0 && v1) begin
            return rr ? 2'b10 : 2'b01;
        end
        return {v1, v0};
    endfunction

endpackage

// File: rtl/csk_wide_add_seq_csk16.sv
// 16-bit carry-skip adder: four 4-bit ripple blocks, each with a propagate-driven skip mux.
// Output bit 16 is the carry-out.
module csk_wide_add_seq_csk16
    import csk_wide_add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_c,
    output logic [WORD_W:0]   o_s
);

    logic [WORD_W-1:0] w_sum;
    logic              w_cblk;
    logic              w_rc;
    logic              w_p;
    logic              w_x;

    always_comb begin
        w_sum  = '0;
        w_cblk = i_c;
        w_rc   = 1'b0;
        w_p    = 1'b0;
        w_x    = 1'b0;
        for (int blk = 0; blk < int'(WORD_W / CSK_BLK); blk++) begin
            w_rc = w_cblk;
            w_p  = 1'b1;
            for (int bt = 0; bt < int'(CSK_BLK); bt++) begin
                w_x                      = i_a[blk*CSK_BLK+bt] ^ i_b[blk*CSK_BLK+bt];
                w_sum[blk*CSK_BLK+bt]    = w_x ^ w_rc;
                w_rc                     = (i_a[blk*CSK_BLK+bt] & i_b[blk*CSK_BLK+bt]) | (w_rc & w_x);
                w_p                      = w_p & w_x;
            end
            // A fully-propagating block forwards its carry-in past the ripple chain.
            w_cblk = w_p ? w_cblk : w_rc;
        end
        o_s = {w_cblk, w_sum};
    end

endmodule

// File: rtl/csk_wide_add_seq.sv
// Two-requester wide-operand adder: round-robin accept, then one 16-bit word per cycle
// through a shared carry-skip adder with the carry chained through a register.
module csk_wide_add_seq
    import csk_wide_add_seq_pkg::*;
#(
    parameter int unsigned NWORDS = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req0_valid,
    output logic                       o_req0_ready,
    input  logic [WORD_W*NWORDS-1:0]   i_req0_a,
    input  logic [WORD_W*NWORDS-1:0]   i_req0_b,
    input  logic                       i_req0_c,
    input  logic                       i_req1_valid,
    output logic                       o_req1_ready,
    input  logic [WORD_W*NWORDS-1:0]   i_req1_a,
    input  logic [WORD_W*NWORDS-1:0]   i_req1_b,
    input  logic                       i_req1_c,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic                       o_rsp_id,
    output logic [WORD_W*NWORDS:0]     o_rsp_s
);

    localparam int unsigned W = WORD_W * NWORDS;
    localparam int unsigned KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    state_e          r_state;
    req_id_t         r_rr;
    req_id_t         r_id;
    logic [KW-1:0]   r_k;
    logic            r_cr;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W:0]      r_sum;

    logic [1:0]        w_grant;
    logic              w_idle;
    logic [WORD_W-1:0] w_a_word;
    logic [WORD_W-1:0] w_b_word;
    logic [WORD_W:0]   w_add;

    assign w_grant = arb_grant(i_req0_valid, i_req1_valid, r_rr);
    assign w_idle  = (r_state == StIdle);

    // Gated by the reset pin so no ready escapes while reset is held.
    assign o_req0_ready = i_rst_n & w_idle & w_grant[0];
    assign o_req1_ready = i_rst_n & w_idle & w_grant[1];

    assign o_rsp_valid = (r_state == StDone);
    assign o_rsp_id    = r_id;
    assign o_rsp_s     = r_sum;

    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int i = 0; i < int'(NWORDS); i++) begin
            if (r_k == i[KW-1:0]) begin
                w_a_word = r_a[i*WORD_W +: WORD_W];
                w_b_word = r_b[i*WORD_W +: WORD_W];
            end
        end
    end

    csk_wide_add_seq_csk16 u_csk16 (
        .i_a (w_a_word),
        .i_b (w_b_word),
        .i_c (r_cr),
        .o_s (w_add)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_rr    <= 1'b0;
            r_id    <= 1'b0;
            r_k     <= '0;
            r_cr    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (|w_grant) begin
                        r_id    <= w_grant[1];
                        r_a     <= w_grant[1] ? i_req1_a : i_req0_a;
                        r_b     <= w_grant[1] ? i_req1_b : i_req0_b;
                        r_cr    <= w_grant[1] ? i_req1_c : i_req0_c;
                        r_k     <= '0;
                        r_rr    <= ~w_grant[1];
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    for (int i = 0; i < int'(NWORDS); i++) begin
                        if (r_k == i[KW-1:0]) begin
                            r_sum[i*WORD_W +: WORD_W] <= w_add[WORD_W-1:0];
                        end
                    end
                    r_cr <= w_add[WORD_W];
                    if (r_k == K_LAST) begin
                        r_sum[W] <= w_add[WORD_W];
                        r_k      <= '0;
                        r_state  <= StDone;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                StDone: begin
                    if (i_rsp_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
